// File: rtl/cc20p_seq_pkg.sv
// Shared types and constants for the ChaCha20-Poly1305 message sequencer.
package cc20p_seq_pkg;

    localparam int BLK_W  = 128;
    localparam int KS_W   = 512;
    localparam int SLICES = 4;
    localparam int KEEP_W = BLK_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_AAD,
        S_KSREQ,
        S_KSWAIT,
        S_PLD,
        S_LEN,
        S_TAG
    } state_t;

    // Byte-enable mask for a final block holding rem bytes (0 means a full block).
    function automatic logic [KEEP_W-1:0] keep_from_rem(input logic [3:0] rem);
        logic [KEEP_W-1:0] k;
        if (rem == 4'd0) k = {KEEP_W{1'b1}};
        else             k = (16'd1 << rem) - 16'd1;
        return k;
    endfunction

endpackage

// File: rtl/cc20p_seq_buf.sv
// One-entry beat buffer that fans out to SINKS consumers; it frees only once
// every consumer has taken the beat, in any order.
module cc20p_seq_buf
    import cc20p_seq_pkg::*;
#(
    parameter int SINKS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic [SINKS-1:0]  ready,
    output logic [SINKS-1:0]  valid,
    output logic              full,
    output logic              free,
    output logic [BLK_W-1:0]  data,
    output logic [KEEP_W-1:0] keep
);

    logic              full_reg;
    logic [SINKS-1:0]  acc_reg;
    logic [SINKS-1:0]  fin;
    logic [BLK_W-1:0]  data_reg;
    logic [KEEP_W-1:0] keep_reg;

    for (genvar gi = 0; gi < SINKS; gi++) begin : g_sink
        assign valid[gi] = full_reg && !acc_reg[gi];
        assign fin[gi]   = acc_reg[gi] || (valid[gi] && ready[gi]);
    end

    assign free = full_reg && (&fin);
    assign full = full_reg;
    assign data = data_reg;
    assign keep = keep_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            acc_reg  <= '0;
            data_reg <= '0;
            keep_reg <= '0;
        end else if (free) begin
            full_reg <= 1'b0;
            acc_reg  <= '0;
        end else if (full_reg) begin
            acc_reg  <= fin;
        end else if (load) begin
            full_reg <= 1'b1;
            data_reg <= load_data;
            keep_reg <= load_keep;
        end
    end

endmodule

// File: rtl/chacha20_poly1305_seq.sv
// Sequencer driving chacha20_poly1305_core: configures it, streams AAD and
// payload, XORs keystream into the payload, sends lengths and forms the tag.
module chacha20_poly1305_seq
    import cc20p_seq_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              decrypt,
    input  logic [LEN_W-1:0]  aad_len,
    input  logic [LEN_W-1:0]  pld_len,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic [BLK_W-1:0]  tag,
    output logic              cfg_we,
    output logic              ks_req,
    input  logic              ks_valid,
    input  logic [KS_W-1:0]   ks_data,
    output logic              aad_valid,
    input  logic              aad_ready,
    output logic [BLK_W-1:0]  aad_data,
    output logic [KEEP_W-1:0] aad_keep,
    output logic              pld_valid,
    input  logic              pld_ready,
    output logic [BLK_W-1:0]  pld_data,
    output logic [KEEP_W-1:0] pld_keep,
    output logic              len_valid,
    input  logic              len_ready,
    output logic [BLK_W-1:0]  len_block,
    input  logic [BLK_W-1:0]  tag_pre_xor,
    input  logic              tag_pre_xor_valid,
    input  logic [BLK_W-1:0]  tagmask,
    input  logic              tagmask_valid
);

    function automatic logic [LEN_W-1:0] n_blocks(input logic [LEN_W-1:0] len);
        return (len >> 4) + LEN_W'(|len[3:0]);
    endfunction

    state_t            state_reg, state_next;
    logic              decrypt_reg;
    logic [LEN_W-1:0]  aad_len_reg, pld_len_reg;
    logic [LEN_W-1:0]  aad_left_reg, pld_left_reg;
    logic [1:0]        slice_reg;
    logic [KS_W-1:0]   ks_reg;
    logic              busy_reg, done_reg;
    logic [BLK_W-1:0]  tag_reg, tpx_reg, tm_reg;
    logic              tpx_seen_reg, tm_seen_reg;

    logic              aad_full, aad_load, aad_free, aad_last;
    logic              pld_full, pld_load, pld_free, pld_last;
    logic [KEEP_W-1:0] aad_load_keep, pld_load_keep, pld_keep_buf;
    logic [BLK_W-1:0]  pld_raw, text_out, tpx_sel, tm_sel;
    logic [1:0]        pld_vld;
    logic              tag_go;

    assign aad_last      = (aad_left_reg == LEN_W'(1));
    assign pld_last      = (pld_left_reg == LEN_W'(1));
    assign aad_load_keep = aad_last ? keep_from_rem(aad_len_reg[3:0]) : {KEEP_W{1'b1}};
    assign pld_load_keep = pld_last ? keep_from_rem(pld_len_reg[3:0]) : {KEEP_W{1'b1}};
    assign aad_load      = in_valid && in_ready && (state_reg == S_AAD);
    assign pld_load      = in_valid && in_ready && (state_reg == S_PLD);

    cc20p_seq_buf #(.SINKS(1)) u_aad_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (aad_load),
        .load_data (in_data),
        .load_keep (aad_load_keep),
        .ready     (aad_ready),
        .valid     (aad_valid),
        .full      (aad_full),
        .free      (aad_free),
        .data      (aad_data),
        .keep      (aad_keep)
    );

    // Sink 1 is the host output stream, sink 0 the core payload port.
    cc20p_seq_buf #(.SINKS(2)) u_pld_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pld_load),
        .load_data (in_data),
        .load_keep (pld_load_keep),
        .ready     ({out_ready, pld_ready}),
        .valid     (pld_vld),
        .full      (pld_full),
        .free      (pld_free),
        .data      (pld_raw),
        .keep      (pld_keep_buf)
    );

    assign text_out  = pld_raw ^ ks_reg[BLK_W*slice_reg +: BLK_W];
    assign out_valid = pld_vld[1];
    assign pld_valid = pld_vld[0];
    assign out_data  = text_out;
    assign pld_data  = decrypt_reg ? pld_raw : text_out;
    assign out_keep  = pld_keep_buf;
    assign pld_keep  = pld_keep_buf;
    assign len_block = (state_reg == S_LEN) ? {64'(pld_len_reg), 64'(aad_len_reg)} : '0;

    assign tpx_sel = tpx_seen_reg ? tpx_reg : tag_pre_xor;
    assign tm_sel  = tm_seen_reg ? tm_reg : tagmask;
    assign tag_go  = (tpx_seen_reg || tag_pre_xor_valid) && (tm_seen_reg || tagmask_valid);

    assign busy = busy_reg;
    assign done = done_reg;
    assign tag  = tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cfg_we     = 1'b0;
        ks_req     = 1'b0;
        in_ready   = 1'b0;
        len_valid  = 1'b0;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_CFG;
            S_CFG: begin
                cfg_we = 1'b1;
                if (aad_left_reg != '0)      state_next = S_AAD;
                else if (pld_left_reg != '0) state_next = S_KSREQ;
                else                         state_next = S_LEN;
            end
            S_AAD: begin
                in_ready = !aad_full;
                if (aad_free && aad_last)
                    state_next = (pld_left_reg != '0) ? S_KSREQ : S_LEN;
            end
            S_KSREQ: begin
                ks_req     = 1'b1;
                state_next = S_KSWAIT;
            end
            S_KSWAIT: if (ks_valid) state_next = S_PLD;
            S_PLD: begin
                in_ready = !pld_full;
                if (pld_free) begin
                    if (pld_last)                           state_next = S_LEN;
                    else if (slice_reg == 2'(SLICES - 1))   state_next = S_KSREQ;
                end
            end
            S_LEN: begin
                len_valid = 1'b1;
                if (len_ready) state_next = S_TAG;
            end
            S_TAG:    if (tag_go) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decrypt_reg  <= 1'b0;
            aad_len_reg  <= '0;
            pld_len_reg  <= '0;
            aad_left_reg <= '0;
            pld_left_reg <= '0;
            slice_reg    <= '0;
            ks_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            tag_reg      <= '0;
            tpx_reg      <= '0;
            tm_reg       <= '0;
            tpx_seen_reg <= 1'b0;
            tm_seen_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: if (start) begin
                    decrypt_reg  <= decrypt;
                    aad_len_reg  <= aad_len;
                    pld_len_reg  <= pld_len;
                    aad_left_reg <= n_blocks(aad_len);
                    pld_left_reg <= n_blocks(pld_len);
                    busy_reg     <= 1'b1;
                    tpx_seen_reg <= 1'b0;
                    tm_seen_reg  <= 1'b0;
                end
                S_AAD: if (aad_free) aad_left_reg <= aad_left_reg - LEN_W'(1);
                S_KSWAIT: if (ks_valid) begin
                    ks_reg    <= ks_data;
                    slice_reg <= 2'd0;
                end
                S_PLD: if (pld_free) begin
                    pld_left_reg <= pld_left_reg - LEN_W'(1);
                    slice_reg    <= slice_reg + 2'd1;
                end
                S_TAG: begin
                    // The two tag halves may arrive in different cycles; hold each.
                    if (tag_pre_xor_valid && !tpx_seen_reg) begin
                        tpx_reg      <= tag_pre_xor;
                        tpx_seen_reg <= 1'b1;
                    end
                    if (tagmask_valid && !tm_seen_reg) begin
                        tm_reg      <= tagmask;
                        tm_seen_reg <= 1'b1;
                    end
                    if (tag_go) begin
                        tag_reg  <= tpx_sel ^ tm_sel;
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha20_poly1305_seq.sv
// Self-checking bench: table of messages, stub core, byte-level AEAD stream model.
module tb_chacha20_poly1305_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, decrypt = 1'b0;
    logic [31:0]  aad_len = '0, pld_len = '0;
    logic         busy, done;
    logic         in_valid = 1'b0, in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid, out_ready = 1'b1;
    logic [127:0] out_data;
    logic [15:0]  out_keep;
    logic [127:0] tag;
    logic         cfg_we, ks_req;
    logic         ks_valid = 1'b0;
    logic [511:0] ks_data = '0;
    logic         aad_valid, aad_ready = 1'b1;
    logic [127:0] aad_data;
    logic [15:0]  aad_keep;
    logic         pld_valid, pld_ready = 1'b1;
    logic [127:0] pld_data;
    logic [15:0]  pld_keep;
    logic         len_valid, len_ready = 1'b1;
    logic [127:0] len_block;
    logic [127:0] tag_pre_xor = '0, tagmask = '0;
    logic         tag_pre_xor_valid = 1'b0, tagmask_valid = 1'b0;

    always #5 clk = ~clk;

    chacha20_poly1305_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt),
        .aad_len(aad_len), .pld_len(pld_len), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .tag(tag), .cfg_we(cfg_we), .ks_req(ks_req), .ks_valid(ks_valid), .ks_data(ks_data),
        .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data), .aad_keep(aad_keep),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data), .pld_keep(pld_keep),
        .len_valid(len_valid), .len_ready(len_ready), .len_block(len_block),
        .tag_pre_xor(tag_pre_xor), .tag_pre_xor_valid(tag_pre_xor_valid),
        .tagmask(tagmask), .tagmask_valid(tagmask_valid)
    );

    typedef struct {
        bit           dec;
        int unsigned  alen, plen;
        bit           a5, bp;
        int           d_tm, d_tp;
        bit           restart;
        int           n_a, n_p, n_ks;
        logic [15:0]  akeep, pkeep;
        logic [127:0] lenb;
    } vec_t;

    vec_t vecs[7];

    int n_err = 0, n_checks = 0;

    logic [127:0] aad_in[$], pld_in[$];
    logic [511:0] ks_hist[$];
    logic [127:0] aad_got[$], pld_got[$], out_got[$], len_got[$];
    logic [15:0]  aad_kgot[$], pld_kgot[$], out_kgot[$];
    int           ks_at[$];
    int           n_cfg, n_done, n_in_pld, bp_viol;
    int           bp_mode = 0, ks_a5 = 0, d_tm = 1, d_tp = 1;
    int           o_stalled, p_stalled, stall_o = 0, stall_p = 0;
    logic [127:0] exp_tag;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Byte b of a block is enabled iff it lies inside the message length.
    function automatic logic [15:0] exp_keep(input int unsigned len, input int b);
        logic [15:0] k;
        k = '0;
        for (int j = 0; j < 16; j++)
            if (16 * b + j < len) k[j] = 1'b1;
        return k;
    endfunction

    // Payload byte i is XORed with byte i of the concatenated keystream blocks.
    function automatic logic [127:0] exp_text(input int b);
        logic [127:0] r;
        logic [511:0] blk;
        int           i;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            i   = 16 * b + j;
            blk = (i / 64 < ks_hist.size()) ? ks_hist[i / 64] : '0;
            r[8*j +: 8] = pld_in[b][8*j +: 8] ^ blk[8*(i % 64) +: 8];
        end
        return r;
    endfunction

    // Transfer monitor, sampled mid-cycle.
    always @(negedge clk) if (rst_n) begin
        if (cfg_we) n_cfg++;
        if (ks_req) ks_at.push_back(pld_got.size());
        if (aad_valid && aad_ready) begin aad_got.push_back(aad_data); aad_kgot.push_back(aad_keep); end
        if (pld_valid && pld_ready) begin pld_got.push_back(pld_data); pld_kgot.push_back(pld_keep); end
        if (out_valid && out_ready) begin out_got.push_back(out_data); out_kgot.push_back(out_keep); end
        if (len_valid && len_ready) len_got.push_back(len_block);
        if (done) n_done++;
        if (n_in_pld > ((out_got.size() < pld_got.size()) ? out_got.size() : pld_got.size()) + 1)
            bp_viol = 1;
    end

    // Sink backpressure, including one 10-cycle stall per side per message.
    initial forever begin
        @(posedge clk); #1;
        if (bp_mode == 0) begin
            out_ready = 1; pld_ready = 1; aad_ready = 1; len_ready = 1;
        end else begin
            aad_ready = ($urandom_range(0, 3) != 0);
            len_ready = $urandom_range(0, 1);
            if (out_valid && !o_stalled) begin o_stalled = 1; stall_o = 10; end
            if (pld_valid && pld_got.size() == 2 && !p_stalled) begin p_stalled = 1; stall_p = 10; end
            if (stall_o > 0) begin out_ready = 0; stall_o--; end
            else out_ready = ($urandom_range(0, 2) != 0);
            if (stall_p > 0) begin pld_ready = 0; stall_p--; end
            else pld_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Core keystream stub.
    initial forever begin
        logic [511:0] blk;
        @(negedge clk);
        if (rst_n && ks_req) begin
            blk = ks_a5 ? {64{8'hA5}} : {rand128(), rand128(), rand128(), rand128()};
            ks_hist.push_back(blk);
            repeat (2) @(posedge clk);
            #1 ks_valid = 1; ks_data = blk;
            @(posedge clk); #1 ks_valid = 0;
        end
    end

    // Core tag stub: each half pulses once, after its own delay from the len transfer.
    initial forever begin
        int mx;
        @(negedge clk);
        if (rst_n && len_valid && len_ready) begin
            mx = (d_tm > d_tp) ? d_tm : d_tp;
            for (int c = 1; c <= mx; c++) begin
                @(posedge clk); #1;
                tagmask_valid     = (c == d_tm);
                tag_pre_xor_valid = (c == d_tp);
            end
            @(posedge clk); #1;
            tagmask_valid = 0; tag_pre_xor_valid = 0;
        end
    end

    task automatic host_feed();
        int total, w;
        total = aad_in.size() + pld_in.size();
        for (int b = 0; b < total; b++) begin
            if (bp_mode != 0 && $urandom_range(0, 3) == 0) begin
                in_valid = 0; @(posedge clk); #1;
            end
            in_valid = 1;
            in_data  = (b < aad_in.size()) ? aad_in[b] : pld_in[b - aad_in.size()];
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 5000) begin @(negedge clk); w++; end
            @(posedge clk); #1;
            if (b >= aad_in.size()) n_in_pld++;
        end
        in_valid = 0;
    endtask

    task automatic setup_msg(input vec_t v);
        aad_in.delete(); pld_in.delete(); ks_hist.delete(); ks_at.delete();
        aad_got.delete(); pld_got.delete(); out_got.delete(); len_got.delete();
        aad_kgot.delete(); pld_kgot.delete(); out_kgot.delete();
        n_cfg = 0; n_done = 0; n_in_pld = 0; bp_viol = 0; o_stalled = 0; p_stalled = 0;
        bp_mode = v.bp; ks_a5 = v.a5; d_tm = v.d_tm; d_tp = v.d_tp;
        for (int b = 0; b < (v.alen + 15) / 16; b++) aad_in.push_back(rand128());
        for (int b = 0; b < (v.plen + 15) / 16; b++) pld_in.push_back(rand128());
        tag_pre_xor = rand128(); tagmask = rand128();
        exp_tag = tag_pre_xor ^ tagmask;
        @(posedge clk); #1;
        decrypt = v.dec; aad_len = v.alen; pld_len = v.plen; start = 1;
        @(posedge clk); #1;
        start = 0; decrypt = ~v.dec; aad_len = $urandom; pld_len = $urandom;
    endtask

    task automatic run_row(input vec_t v, input int idx);
        logic [127:0] et;
        setup_msg(v);
        fork
            host_feed();
            if (v.restart) begin
                repeat (6) @(posedge clk);
                #1 start = 1; aad_len = 7; pld_len = 3;
                @(posedge clk); #1 start = 0;
            end
        join_none
        for (int c = 0; c < 5000 && n_done == 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        disable fork;
        in_valid = 0;
        chk("cfg_we_pulses", n_cfg, 1);
        chk("aad_xfers", aad_got.size(), v.n_a);
        for (int b = 0; b < aad_got.size() && b < aad_in.size(); b++) begin
            chk("aad_data", aad_got[b], aad_in[b]);
            chk("aad_keep", aad_kgot[b], exp_keep(v.alen, b));
        end
        if (v.n_a > 0 && aad_kgot.size() == v.n_a) chk("aad_last_keep", aad_kgot[v.n_a-1], v.akeep);
        chk("ks_req_pulses", ks_at.size(), v.n_ks);
        foreach (ks_at[k]) chk("ks_req_after_pld", ks_at[k], 4 * k);
        chk("pld_xfers", pld_got.size(), v.n_p);
        chk("out_xfers", out_got.size(), v.n_p);
        for (int b = 0; b < v.n_p && b < pld_got.size() && b < out_got.size(); b++) begin
            et = exp_text(b);
            chk("out_data", out_got[b], et);
            chk("pld_data", pld_got[b], v.dec ? pld_in[b] : et);
            chk("out_keep", out_kgot[b], exp_keep(v.plen, b));
            chk("pld_keep", pld_kgot[b], exp_keep(v.plen, b));
        end
        if (v.n_p > 0 && out_kgot.size() == v.n_p) chk("out_last_keep", out_kgot[v.n_p-1], v.pkeep);
        chk("len_xfers", len_got.size(), 1);
        if (len_got.size() > 0) chk("len_block", len_got[0], v.lenb);
        chk("tag", tag, exp_tag);
        chk("done_pulses", n_done, 1);
        chk("busy_after_done", busy, 0);
        chk("buffer_frees_after_both", bp_viol, 0);
        $display("msg %0d: dec=%0d aad_len=%0d pld_len=%0d aad=%0d pld=%0d out=%0d ks_req=%0d done=%0d",
                 idx, v.dec, v.alen, v.plen, aad_got.size(), pld_got.size(), out_got.size(),
                 ks_at.size(), n_done);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_ctrl"}, {busy, done, cfg_we, ks_req, in_ready, out_valid, aad_valid,
                              pld_valid, len_valid}, 0);
        chk({name, "_tag"}, tag, 0);
        chk({name, "_data"}, out_data | pld_data | aad_data | len_block, 0);
        chk({name, "_keep"}, {out_keep, pld_keep, aad_keep}, 0);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{0, 32, 32,  1, 0, 1, 1, 0, 2, 2, 1, 16'hFFFF, 16'hFFFF, {64'd32, 64'd32}};
        vecs[1] = '{0, 0, 80,   0, 0, 2, 1, 0, 0, 5, 2, 16'hFFFF, 16'hFFFF, {64'd80, 64'd0}};
        vecs[2] = '{0, 5, 21,   0, 0, 1, 2, 0, 1, 2, 1, 16'h001F, 16'h001F, {64'd21, 64'd5}};
        vecs[3] = '{1, 48, 100, 0, 1, 3, 1, 0, 3, 7, 2, 16'hFFFF, 16'h000F, {64'd100, 64'd48}};
        vecs[4] = '{0, 0, 0,    0, 0, 1, 4, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 128'd0};
        vecs[5] = '{1, 17, 64,  0, 1, 2, 2, 1, 2, 4, 1, 16'h0001, 16'hFFFF, {64'd64, 64'd17}};
        vecs[6] = '{0, 1, 129,  0, 1, 1, 3, 0, 1, 9, 3, 16'h0001, 16'h0001, {64'd129, 64'd1}};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst_n = 1;

        for (int i = 0; i < 5; i++) run_row(vecs[i], i);

        // Abort a payload mid-stream with reset.
        rv = vecs[1];
        setup_msg(rv);
        fork host_feed(); join_none
        for (int c = 0; c < 2000 && pld_got.size() < 2; c++) @(posedge clk);
        chk("pld_progress_before_abort", pld_got.size() >= 2, 1);
        @(posedge clk); #1 rst_n = 0;
        disable fork;
        in_valid = 0;
        @(negedge clk);
        check_idle_outputs("mid_pld_reset");
        $display("abort: reset asserted after %0d pld transfers", pld_got.size());
        repeat (10) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        for (int i = 5; i < 7; i++) run_row(vecs[i], i);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/chacha20_poly1305_seq.md
Name: chacha20_poly1305_seq

Overview:
Message sequencer that drives chacha20_poly1305_core as its initiator.
- Accepts one AEAD message from the host as 128-bit beats: AAD blocks first, then payload blocks.
- Pulses cfg_we on the core, then feeds the core's AAD, payload and length interfaces.
- Requests keystream and XORs it with the payload to produce the output text.
- Combines tag_pre_xor with tagmask to produce the final tag.
- Sits between the host DMA/stream layer and the core.

Parameters:
LEN_W, 32, width of the AAD and payload byte-count inputs.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a message; ignored while busy=1
decrypt  in  1  sampled at start; 0 = core payload port gets the output text, 1 = core payload port gets the input text
aad_len  in  LEN_W  AAD byte count, sampled at start
pld_len  in  LEN_W  payload byte count, sampled at start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the tag is valid
in_valid / in_ready / in_data  in/out/in  1/1/128  host input stream, byte 0 in bits [7:0]
out_valid / out_ready / out_data / out_keep  out/in/out/out  1/1/128/16  output payload stream
tag  out  128  final tag, held until the next start
cfg_we  out  1  pulse to the core
ks_req  out  1  pulse to the core
ks_valid / ks_data  in/in  1/512  keystream from the core
aad_valid / aad_ready / aad_data / aad_keep  out/in/out/out  1/1/128/16  core AAD port
pld_valid / pld_ready / pld_data / pld_keep  out/in/out/out  1/1/128/16  core payload port
len_valid / len_ready / len_block  out/in/out  1/1/128  core length port
tag_pre_xor / tag_pre_xor_valid / tagmask / tagmask_valid  in/in/in/in  128/1/128/1  core tag outputs

Behaviour:
Reset and handshake rules:
- Reset: every output low or zero, including tag; state IDLE. Reset mid-message abandons the message with no drain.
- All valid/ready transfers occur on clk rising edges with valid && ready. A valid, once raised, holds its data stable until the transfer.

Block counts and keep masks:
- nA = ceil(aad_len/16); nP = ceil(pld_len/16).
- Last-block keep = (1<<(len%16))-1, or 16'hFFFF when len%16 == 0. All other blocks use keep 16'hFFFF.
- Bytes of in_data beyond the keep mask are forwarded unmodified; the core and the host ignore them.

State machine:
- IDLE: on start, latch the inputs, set busy, go to CFG.
- CFG: cfg_we=1 for exactly one cycle. Next state is AAD if nA>0, else KSREQ if nP>0, else LEN.
- AAD: one-entry buffer.
  - in_ready=1 only while the buffer is empty. An accepted beat loads the buffer.
  - aad_valid=1 while the buffer is full; the buffer is freed on the aad transfer.
  - After the nA-th aad transfer, go to KSREQ if nP>0, else LEN.
- KSREQ: ks_req=1 for one cycle, then KSWAIT.
- KSWAIT: on ks_valid, latch ks_data, set slice=0, go to PLD.
- PLD: one-entry buffer.
  - Output text = in_data ^ ks_data[128*slice +: 128].
  - pld_data = output text when decrypt=0, input text when decrypt=1.
  - out_data = output text; out_keep = pld_keep.
  - Both sinks see a full buffer at once. Per-side accepted flags track completion; the buffer frees only when both sides have transferred, in either order or the same cycle.
  - On free, slice increments. If slice was 3 and payload blocks remain, go to KSREQ.
  - After the nP-th block, go to LEN.
- LEN: len_valid=1 with len_block[63:0]=aad_len and len_block[127:64]=pld_len, both zero-extended little-endian. On the len transfer go to TAG.
- TAG: wait until tag_pre_xor_valid and tagmask_valid are both high, in the same or different cycles (each is latched). Then tag <= tag_pre_xor ^ tagmask; pulse done; clear busy; return to IDLE.

Boundary cases:
- aad_len=0 and pld_len=0: CFG, then LEN, then TAG.
- A start pulse arriving while busy=1 is dropped.

Decomposition:
- Package cc20p_seq_pkg holds:
  - the state enum;
  - BLK_W=128, KS_W=512, SLICES=4;
  - function keep_from_rem(len[3:0]).
- One natural sub-module: cc20p_seq_buf, the one-entry buffer with dual-sink acceptance flags. It is used twice: the AAD instance has one sink tied to accepted.

Test Plan:
- aad_len=32, pld_len=32, decrypt=0, core stub returns ks_data=all 0xA5 -> 2 aad transfers; 1 ks_req; out_data = in ^ {16{8'hA5}}; pld_data == out_data; len_block = {64'd32, 64'd32}; tag = pre_xor ^ mask; exactly 1 done pulse.
- aad_len=0, pld_len=80 (5 blocks) -> zero aad transfers; exactly 2 ks_req pulses, the 2nd after the 4th pld transfer; last out_keep = 16'hFFFF; len_block = {64'd80, 64'd0}.
- pld_len=21, aad_len=5 -> aad_keep = 16'h001F; final pld_keep = out_keep = 16'h001F; len_block = {64'd21, 64'd5}.
- decrypt=1, random out_ready and pld_ready backpressure, including stalls of one side for 10 cycles -> pld_data = in_data; no beat duplicated or lost; the buffer frees only after both sides transfer.
- aad_len=0, pld_len=0 -> cfg_we, then the len transfer with len_block = 0; tagmask_valid arriving 3 cycles before tag_pre_xor_valid still yields the correct tag and done.
- Assert rst_n=0 in the middle of PLD -> all outputs 0 and state IDLE. A new start then completes normally; a start pulsed while busy is ignored.
